// File: rtl/uart_pkg.sv
// uart_pkg: constants shared by the UART-side DMI test access port.
//   IRLENGTH      : width of a DMI/DTM register address inside a command byte
//   CMD_*         : 3-bit command codes carried in the top bits of a command byte
//   ADDR_*        : well-known DTM register addresses
//   ST_*          : tap FSM state encodings
//   dtmcs_merge() : folds the live DMI error status into a captured DTMCS word
package uart_pkg;

    localparam int IRLENGTH = 5;

    localparam logic [2:0] CMD_NOP       = 3'd0;
    localparam logic [2:0] CMD_READ      = 3'd1;
    localparam logic [2:0] CMD_WRITE     = 3'd2;
    localparam logic [2:0] CMD_RESET     = 3'd3;
    localparam logic [2:0] CMD_CONT_READ = 3'd4;

    localparam logic [IRLENGTH-1:0] ADDR_IDCODE = 5'h01;
    localparam logic [IRLENGTH-1:0] ADDR_DTMCS  = 5'h10;
    localparam logic [IRLENGTH-1:0] ADDR_DMI    = 5'h11;

    localparam logic [2:0] ST_IDLE       = 3'd0;
    localparam logic [2:0] ST_READ_REQ   = 3'd1;
    localparam logic [2:0] ST_SEND_HDR   = 3'd2;
    localparam logic [2:0] ST_SEND_DATA  = 3'd3;
    localparam logic [2:0] ST_WRITE_RECV = 3'd4;
    localparam logic [2:0] ST_WRITE_REQ  = 3'd5;

    // DTMCS bits [11:10] report the DMI error status, which lives outside
    // the register block, so it is spliced in at capture time.
    function automatic logic [11:0] dtmcs_merge(input logic [11:0] low,
                                                input logic [1:0]  err);
        logic [11:0] r;
        r        = low;
        r[11:10] = err;
        return r;
    endfunction

endpackage

// File: rtl/dmi_uart_tap.sv
// dmi_uart_tap: turns framed command bytes from a UART RX FIFO into DMI/DTM
// register reads and writes, and streams read results back over UART TX.
//
// Ports:
//   CLK_I, RST_NI                        clock, synchronous active-low reset
//   READ_O, DATA_REC_I, RX_EMPTY_I,
//   CMD_REC_I                            RX FIFO pop / head byte / status
//   TX_READY_I, WRITE_O, DATA_SEND_O,
//   SEND_COMMAND_O, COMMAND_O            UART transmit path
//   DMI_HARD_RESET_O                     one-cycle DMI hard reset pulse
//   DMI_ERROR_I                          DMI error status (into DTMCS reads)
//   WRITE_ADDRESS_O, WRITE_DATA_O,
//   WRITE_VALID_O, WRITE_READY_I         register write request channel
//   READ_ADDRESS_O, READ_DATA_I,
//   READ_VALID_I, READ_READY_O           register read channel
//   VALID_ADDRESS_I                      address whose data is fresh
//
// state        | meaning
// -------------+--------------------------------------------------------
// IDLE         | pop RX head; command bytes are dispatched, data dropped
// READ_REQ     | READ_READY_O high until register data is captured
// SEND_HDR     | transmit the read header command byte
// SEND_DATA    | transmit NB data bytes, LSB byte first
// WRITE_RECV   | pop NB data bytes into the write shift register
// WRITE_REQ    | WRITE_VALID_O high until WRITE_READY_I
module dmi_uart_tap
    import uart_pkg::*;
#(
    parameter int WIDTH = 41
) (
    input  logic                CLK_I,
    input  logic                RST_NI,
    output logic                READ_O,
    input  logic [7:0]          DATA_REC_I,
    input  logic                RX_EMPTY_I,
    input  logic                CMD_REC_I,
    input  logic                TX_READY_I,
    output logic                WRITE_O,
    output logic [7:0]          DATA_SEND_O,
    output logic                SEND_COMMAND_O,
    output logic [7:0]          COMMAND_O,
    output logic                DMI_HARD_RESET_O,
    input  logic [1:0]          DMI_ERROR_I,
    output logic [IRLENGTH-1:0] WRITE_ADDRESS_O,
    output logic [WIDTH-1:0]    WRITE_DATA_O,
    output logic                WRITE_VALID_O,
    input  logic                WRITE_READY_I,
    output logic [IRLENGTH-1:0] READ_ADDRESS_O,
    input  logic [WIDTH-1:0]    READ_DATA_I,
    input  logic                READ_VALID_I,
    output logic                READ_READY_O,
    input  logic [IRLENGTH-1:0] VALID_ADDRESS_I
);

    localparam int NB  = (WIDTH + 7) / 8;
    localparam int SRW = NB * 8;
    localparam int CW  = $clog2(NB + 1);

    logic [2:0]          state;
    logic [IRLENGTH-1:0] addr;
    logic                cont;
    logic                repeat_rd;
    logic [CW-1:0]       byte_cnt;
    logic [SRW-1:0]      shreg;
    logic                hard_reset;

    logic                cmd_at_head;
    logic                rd_accept;
    logic [WIDTH-1:0]    rd_cap;

    assign cmd_at_head = !RX_EMPTY_I && CMD_REC_I;

    // Repeats of a continuous read only accept data the register block
    // flags as refreshed for our address.
    assign rd_accept = READ_VALID_I && (!repeat_rd || (VALID_ADDRESS_I == addr));

    always_comb begin
        rd_cap = READ_DATA_I;
        if (addr == ADDR_DTMCS) begin
            rd_cap[11:0] = dtmcs_merge(READ_DATA_I[11:0], DMI_ERROR_I);
        end
    end

    always_ff @(posedge CLK_I) begin
        if (!RST_NI) begin
            state      <= ST_IDLE;
            addr       <= '0;
            cont       <= 1'b0;
            repeat_rd  <= 1'b0;
            byte_cnt   <= '0;
            shreg      <= '0;
            hard_reset <= 1'b0;
        end else begin
            hard_reset <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (cmd_at_head) begin
                        addr      <= DATA_REC_I[IRLENGTH-1:0];
                        repeat_rd <= 1'b0;
                        case (DATA_REC_I[7:IRLENGTH])
                            CMD_READ: begin
                                cont  <= 1'b0;
                                state <= ST_READ_REQ;
                            end
                            CMD_CONT_READ: begin
                                cont  <= 1'b1;
                                state <= ST_READ_REQ;
                            end
                            CMD_WRITE: begin
                                byte_cnt <= CW'(NB - 1);
                                state    <= ST_WRITE_RECV;
                            end
                            CMD_RESET: hard_reset <= 1'b1;
                            default: ;
                        endcase
                    end
                end
                ST_READ_REQ: begin
                    if (rd_accept) begin
                        shreg <= SRW'(rd_cap);
                        state <= ST_SEND_HDR;
                    end
                end
                ST_SEND_HDR: begin
                    if (TX_READY_I) begin
                        byte_cnt <= CW'(NB - 1);
                        state    <= ST_SEND_DATA;
                    end
                end
                ST_SEND_DATA: begin
                    if (TX_READY_I) begin
                        // zeros shift in, so the last byte's unused bits are 0
                        shreg <= shreg >> 8;
                        if (byte_cnt == '0) begin
                            // a pending command byte ends the loop; IDLE pops it
                            if (cont && !cmd_at_head) begin
                                repeat_rd <= 1'b1;
                                state     <= ST_READ_REQ;
                            end else begin
                                state <= ST_IDLE;
                            end
                        end else begin
                            byte_cnt <= byte_cnt - 1'b1;
                        end
                    end
                end
                ST_WRITE_RECV: begin
                    if (!RX_EMPTY_I) begin
                        if (CMD_REC_I) begin
                            state <= ST_IDLE;
                        end else begin
                            shreg <= (shreg >> 8) | (SRW'(DATA_REC_I) << (SRW - 8));
                            if (byte_cnt == '0) begin
                                state <= ST_WRITE_REQ;
                            end else begin
                                byte_cnt <= byte_cnt - 1'b1;
                            end
                        end
                    end
                end
                ST_WRITE_REQ: begin
                    if (WRITE_READY_I) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign READ_O = RST_NI && !RX_EMPTY_I &&
                    ((state == ST_IDLE) || ((state == ST_WRITE_RECV) && !CMD_REC_I));

    assign READ_READY_O   = (state == ST_READ_REQ);
    assign READ_ADDRESS_O = (state == ST_READ_REQ) ? addr : '0;

    assign SEND_COMMAND_O = (state == ST_SEND_HDR);
    assign COMMAND_O      = (state == ST_SEND_HDR) ? {CMD_READ, addr} : 8'h00;
    assign DATA_SEND_O    = (state == ST_SEND_DATA) ? shreg[7:0] : 8'h00;
    assign WRITE_O        = TX_READY_I && ((state == ST_SEND_HDR) || (state == ST_SEND_DATA));

    assign WRITE_VALID_O   = (state == ST_WRITE_REQ);
    assign WRITE_ADDRESS_O = (state == ST_WRITE_REQ) ? addr : '0;
    assign WRITE_DATA_O    = (state == ST_WRITE_REQ) ? shreg[WIDTH-1:0] : '0;

    assign DMI_HARD_RESET_O = hard_reset;

endmodule

// File: tb/tb_dmi_uart_tap.sv
// tb_dmi_uart_tap: directed, scoreboard-checked bench for dmi_uart_tap.
// An RX FIFO model feeds command/data bytes; expected TX items and register
// writes are queued when stimulus is issued and checked as the DUT emits them.
module tb_dmi_uart_tap;

    logic        CLK_I = 1'b0;
    logic        RST_NI;
    logic        READ_O;
    logic [7:0]  DATA_REC_I = 8'h00;
    logic        RX_EMPTY_I = 1'b1;
    logic        CMD_REC_I = 1'b0;
    logic        TX_READY_I;
    logic        WRITE_O;
    logic [7:0]  DATA_SEND_O;
    logic        SEND_COMMAND_O;
    logic [7:0]  COMMAND_O;
    logic        DMI_HARD_RESET_O;
    logic [1:0]  DMI_ERROR_I;
    logic [4:0]  WRITE_ADDRESS_O;
    logic [40:0] WRITE_DATA_O;
    logic        WRITE_VALID_O;
    logic        WRITE_READY_I = 1'b0;
    logic [4:0]  READ_ADDRESS_O;
    logic [40:0] READ_DATA_I;
    logic        READ_VALID_I;
    logic        READ_READY_O;
    logic [4:0]  VALID_ADDRESS_I;

    dmi_uart_tap #(.WIDTH(41)) dut (
        .CLK_I(CLK_I), .RST_NI(RST_NI),
        .READ_O(READ_O), .DATA_REC_I(DATA_REC_I), .RX_EMPTY_I(RX_EMPTY_I),
        .CMD_REC_I(CMD_REC_I), .TX_READY_I(TX_READY_I), .WRITE_O(WRITE_O),
        .DATA_SEND_O(DATA_SEND_O), .SEND_COMMAND_O(SEND_COMMAND_O),
        .COMMAND_O(COMMAND_O), .DMI_HARD_RESET_O(DMI_HARD_RESET_O),
        .DMI_ERROR_I(DMI_ERROR_I), .WRITE_ADDRESS_O(WRITE_ADDRESS_O),
        .WRITE_DATA_O(WRITE_DATA_O), .WRITE_VALID_O(WRITE_VALID_O),
        .WRITE_READY_I(WRITE_READY_I), .READ_ADDRESS_O(READ_ADDRESS_O),
        .READ_DATA_I(READ_DATA_I), .READ_VALID_I(READ_VALID_I),
        .READ_READY_O(READ_READY_O), .VALID_ADDRESS_I(VALID_ADDRESS_I)
    );

    always #5 CLK_I = ~CLK_I;

    int tests = 0;
    int fails = 0;
    int pops = 0;
    int tx_cnt = 0;
    int hr_cnt = 0;
    int wr_cnt = 0;
    logic wr_rand = 1'b0;
    logic pop_pend = 1'b0;

    logic [8:0]  rx_q[$];
    logic [8:0]  exp_tx[$];
    logic [4:0]  exp_wa[$];
    logic [40:0] exp_wd[$];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // RX FIFO model: head presented first-word-fall-through, popped on READ_O.
    always @(negedge CLK_I) pop_pend = READ_O;

    always @(posedge CLK_I) begin
        logic [8:0] dummy;
        if (pop_pend && rx_q.size() != 0) begin
            dummy = rx_q.pop_front();
            pops++;
        end
        #1;
        if (rx_q.size() == 0) begin
            RX_EMPTY_I = 1'b1;
            CMD_REC_I  = 1'b0;
            DATA_REC_I = 8'h00;
        end else begin
            RX_EMPTY_I = 1'b0;
            {CMD_REC_I, DATA_REC_I} = rx_q[0];
        end
        WRITE_READY_I = wr_rand ? ($urandom_range(0, 2) == 0) : 1'b0;
    end

    // Output monitor / scoreboard.
    logic        prev_stall = 1'b0;
    logic        prev_xfer = 1'b0;
    logic [40:0] prev_wd = '0;

    always @(negedge CLK_I) begin
        logic [8:0] e;
        if (!RST_NI) begin
            prev_stall = 1'b0;
            prev_xfer  = 1'b0;
        end else begin
            if (READ_O) chk("read_o_when_empty", 64'(RX_EMPTY_I), 64'd0);
            if (WRITE_O) begin
                tx_cnt++;
                chk("tx_needs_ready", 64'(TX_READY_I), 64'd1);
                chk("tx_expected", 64'(exp_tx.size() != 0), 64'd1);
                if (exp_tx.size() != 0) begin
                    e = exp_tx.pop_front();
                    chk("tx_item", 64'({SEND_COMMAND_O, SEND_COMMAND_O ? COMMAND_O : DATA_SEND_O}), 64'(e));
                end
            end
            if (DMI_HARD_RESET_O) hr_cnt++;
            if (prev_stall) begin
                chk("wr_valid_held", 64'(WRITE_VALID_O), 64'd1);
                chk("wr_data_held", 64'(WRITE_DATA_O), 64'(prev_wd));
            end
            if (prev_xfer) chk("wr_valid_drop", 64'(WRITE_VALID_O), 64'd0);
            prev_xfer  = WRITE_VALID_O && WRITE_READY_I;
            prev_stall = WRITE_VALID_O && !WRITE_READY_I;
            prev_wd    = WRITE_DATA_O;
            if (WRITE_VALID_O && WRITE_READY_I) begin
                wr_cnt++;
                chk("wr_expected", 64'(exp_wd.size() != 0), 64'd1);
                if (exp_wd.size() != 0) begin
                    chk("wr_addr", 64'(WRITE_ADDRESS_O), 64'(exp_wa.pop_front()));
                    chk("wr_data", 64'(WRITE_DATA_O), 64'(exp_wd.pop_front()));
                end
            end
        end
    end

    task automatic push_frame(input logic [4:0] a, input logic [40:0] d, input logic [1:0] err);
        logic [40:0] m;
        m = d;
        if (a == 5'h10) m[11:10] = err;
        exp_tx.push_back({1'b1, 3'd1, a});
        for (int i = 0; i < 6; i++) exp_tx.push_back({1'b0, 8'(m >> (8 * i))});
    endtask

    task automatic drain(input string tag, input int budget);
        int n;
        n = 0;
        while ((exp_tx.size() != 0 || rx_q.size() != 0 || exp_wd.size() != 0) && n < budget) begin
            @(negedge CLK_I);
            n++;
        end
        repeat (3) @(negedge CLK_I);
        chk({tag, "_timeout"}, 64'(n < budget), 64'd1);
    endtask

    task automatic wait_tx(input string tag, input int target, input int budget);
        int n;
        n = 0;
        while (tx_cnt < target && n < budget) begin
            @(negedge CLK_I);
            n++;
        end
        chk({tag, "_timeout"}, 64'(n < budget), 64'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        int n;
        int base;
        int pb;
        int wb;
        int c;

        RST_NI = 1'b0;
        TX_READY_I = 1'b1;
        READ_VALID_I = 1'b0;
        READ_DATA_I = '0;
        VALID_ADDRESS_I = '0;
        DMI_ERROR_I = 2'b00;
        repeat (3) @(posedge CLK_I);
        #1 RST_NI = 1'b1;
        @(negedge CLK_I);
        chk("rst_read_o", 64'(READ_O), 64'd0);
        chk("rst_write_o", 64'(WRITE_O), 64'd0);
        chk("rst_read_ready", 64'(READ_READY_O), 64'd0);
        chk("rst_write_valid", 64'(WRITE_VALID_O), 64'd0);
        chk("rst_hard_reset", 64'(DMI_HARD_RESET_O), 64'd0);
        chk("rst_send_cmd", 64'(SEND_COMMAND_O), 64'd0);
        chk("rst_command", 64'(COMMAND_O), 64'd0);
        chk("rst_data_send", 64'(DATA_SEND_O), 64'd0);

        // Single read of IDCODE, data held back to see READ_READY_O wait.
        READ_DATA_I = 41'h1_2345_6789_AB;
        push_frame(5'h01, 41'h1_2345_6789_AB, 2'b00);
        base = tx_cnt;
        rx_q.push_back({1'b1, 3'd1, 5'h01});
        n = 0;
        while (!READ_O && n < 50) begin
            @(negedge CLK_I);
            n++;
        end
        chk("rd_pop_timeout", 64'(n < 50), 64'd1);
        @(negedge CLK_I);
        chk("rd_ready_latency", 64'(READ_READY_O), 64'd1);
        chk("rd_addr", 64'(READ_ADDRESS_O), 64'h01);
        repeat (3) @(negedge CLK_I);
        chk("rd_ready_wait", 64'(READ_READY_O), 64'd1);
        chk("rd_no_tx_before_data", 64'(tx_cnt), 64'(base));
        READ_VALID_I = 1'b1;
        @(negedge CLK_I);
        READ_VALID_I = 1'b0;
        drain("rd_idcode", 200);
        chk("rd_idcode_bytes", 64'(tx_cnt - base), 64'd7);

        // Write to DMI with randomised WRITE_READY_I.
        wr_rand = 1'b1;
        exp_wa.push_back(5'h11);
        exp_wd.push_back(41'h0_0504_0302_01);
        pb = pops;
        wb = wr_cnt;
        rx_q.push_back({1'b1, 3'd2, 5'h11});
        for (int i = 1; i <= 6; i++) rx_q.push_back({1'b0, 8'(i)});
        drain("wr_dmi", 300);
        chk("wr_pops", 64'(pops - pb), 64'd7);
        chk("wr_count", 64'(wr_cnt - wb), 64'd1);
        wr_rand = 1'b0;

        // DTMCS read with error splice, TX stalled for 10 cycles mid-frame.
        DMI_ERROR_I = 2'b10;
        READ_DATA_I = 41'h155_AAAA_0F0F;
        READ_VALID_I = 1'b1;
        push_frame(5'h10, 41'h155_AAAA_0F0F, 2'b10);
        base = tx_cnt;
        rx_q.push_back({1'b1, 3'd1, 5'h10});
        wait_tx("stall_pre", base + 4, 200);
        TX_READY_I = 1'b0;
        @(negedge CLK_I);
        c = tx_cnt;
        repeat (10) @(negedge CLK_I);
        chk("stall_no_tx", 64'(tx_cnt), 64'(c));
        TX_READY_I = 1'b1;
        drain("stall", 200);
        chk("stall_bytes", 64'(tx_cnt - base), 64'd7);
        READ_VALID_I = 1'b0;

        // Continuous read, NOP arrives during the third frame.
        READ_DATA_I = 41'h0A5_5A5A_C3C3;
        VALID_ADDRESS_I = 5'h11;
        READ_VALID_I = 1'b1;
        for (int f = 0; f < 3; f++) push_frame(5'h11, 41'h0A5_5A5A_C3C3, 2'b10);
        base = tx_cnt;
        rx_q.push_back({1'b1, 3'd4, 5'h11});
        wait_tx("cont_pre", base + 15, 500);
        rx_q.push_back({1'b1, 3'd0, 5'h00});
        drain("cont", 300);
        repeat (20) @(negedge CLK_I);
        chk("cont_frames", 64'(tx_cnt - base), 64'd21);
        chk("cont_idle", 64'(READ_READY_O), 64'd0);
        READ_VALID_I = 1'b0;

        // Hard reset pulse.
        base = hr_cnt;
        rx_q.push_back({1'b1, 3'd3, 5'h03});
        drain("hreset", 100);
        repeat (5) @(negedge CLK_I);
        chk("hreset_pulse_cycles", 64'(hr_cnt - base), 64'd1);

        // Write aborted by a command byte after 3 data bytes.
        READ_DATA_I = 41'h0DE_AD00_BEEF;
        READ_VALID_I = 1'b1;
        push_frame(5'h01, 41'h0DE_AD00_BEEF, 2'b10);
        wb = wr_cnt;
        pb = pops;
        base = tx_cnt;
        rx_q.push_back({1'b1, 3'd2, 5'h11});
        rx_q.push_back({1'b0, 8'hAA});
        rx_q.push_back({1'b0, 8'hBB});
        rx_q.push_back({1'b0, 8'hCC});
        rx_q.push_back({1'b1, 3'd1, 5'h01});
        drain("abort", 300);
        repeat (10) @(negedge CLK_I);
        chk("abort_no_write", 64'(wr_cnt), 64'(wb));
        chk("abort_pops", 64'(pops - pb), 64'd5);
        chk("abort_read_bytes", 64'(tx_cnt - base), 64'd7);
        READ_VALID_I = 1'b0;

        // Reset while the header is stalled on TX_READY_I.
        TX_READY_I = 1'b0;
        READ_VALID_I = 1'b1;
        READ_DATA_I = 41'h0_1111_2222;
        rx_q.push_back({1'b1, 3'd1, 5'h05});
        repeat (6) @(negedge CLK_I);
        chk("stalled_hdr_flag", 64'(SEND_COMMAND_O), 64'd1);
        chk("stalled_hdr_byte", 64'(COMMAND_O), 64'({3'd1, 5'h05}));
        base = tx_cnt;
        RST_NI = 1'b0;
        @(negedge CLK_I);
        chk("midrst_send_cmd", 64'(SEND_COMMAND_O), 64'd0);
        chk("midrst_command", 64'(COMMAND_O), 64'd0);
        chk("midrst_read_ready", 64'(READ_READY_O), 64'd0);
        RST_NI = 1'b1;
        TX_READY_I = 1'b1;
        repeat (20) @(negedge CLK_I);
        chk("midrst_no_tx", 64'(tx_cnt), 64'(base));
        chk("midrst_no_pulse", 64'(DMI_HARD_RESET_O), 64'd0);
        READ_VALID_I = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
